// File: rtl/axi_lite_master_if.sv
// Single-outstanding AXI4-Lite master: turns one requester transaction into an AW/W/B or AR/R
// exchange and returns a one-cycle completion pulse with read data and error flag.
module axi_lite_master_if #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESETN,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,

    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [31:0]           M_AXI_WDATA,
    output logic [3:0]            M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [31:0]           M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    typedef enum logic [2:0] {StIdle, StWrite, StWresp, StRead, StRdata} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    resp_err_q, resp_err_d;
    logic [31:0]             rdata_q, rdata_d;

    // Only bit [1] of a response distinguishes OKAY/EXOKAY from SLVERR/DECERR.
    logic unused_resp;
    assign unused_resp = ^{M_AXI_BRESP[0], M_AXI_RRESP[0]};

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q      <= StIdle;
            awaddr_q     <= '0;
            araddr_q     <= '0;
            wdata_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            awaddr_q     <= awaddr_d;
            araddr_q     <= araddr_d;
            wdata_q      <= wdata_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            arvalid_q    <= arvalid_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        awaddr_d     = awaddr_q;
        araddr_d     = araddr_q;
        wdata_d      = wdata_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        arvalid_d    = arvalid_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        rdata_d      = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    awaddr_d = req_addr;
                    araddr_d = req_addr;
                    wdata_d  = req_wdata;
                    if (req_wen) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StWrite;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = StRead;
                    end
                end
            end
            StWrite: begin
                // AW and W retire independently, in either order or together.
                if (M_AXI_AWREADY) awvalid_d = 1'b0;
                if (M_AXI_WREADY)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = StWresp;
            end
            StWresp: begin
                if (M_AXI_BVALID) begin
                    resp_err_d   = M_AXI_BRESP[1];
                    resp_valid_d = 1'b1;
                    state_d      = StIdle;
                end
            end
            StRead: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = StRdata;
                end
            end
            StRdata: begin
                if (M_AXI_RVALID) begin
                    rdata_d      = M_AXI_RDATA;
                    resp_err_d   = M_AXI_RRESP[1];
                    resp_valid_d = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_ready     = (state_q == StIdle);
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = rdata_q;
    assign resp_err      = resp_err_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = (state_q == StWresp);
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = (state_q == StRdata);

endmodule

// File: tb/tb_axi_lite_master_if.sv
// Self-checking bench for axi_lite_master_if: scripted slave timing scenarios plus randomized
// traffic against a memory-backed reference of completions.
module tb_axi_lite_master_if;

    logic        M_AXI_ACLK;
    logic        M_AXI_ARESETN;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  M_AXI_AWADDR;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic [9:0]  M_AXI_ARADDR;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: completion flags and a word-addressed slave memory.
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_err   = 1'b0;
    logic [31:0] mem [256];

    axi_lite_master_if #(.ADDR_WIDTH(10)) dut (
        .M_AXI_ACLK    (M_AXI_ACLK),
        .M_AXI_ARESETN (M_AXI_ARESETN),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wen       (req_wen),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    initial M_AXI_ACLK = 1'b0;
    always #5 M_AXI_ACLK = ~M_AXI_ACLK;

    task automatic step();
        @(posedge M_AXI_ACLK);
        #1;
    endtask

    task automatic run_write(input logic [9:0] addr, input logic [31:0] data, input int aw_dly,
                             input int w_dly, input int b_dly, input logic [1:0] bresp);
        bit aw_pend = 1'b1;
        bit w_pend  = 1'b1;
        int c = 0;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_ready got=%b want=1", req_ready);
        end
        req_valid = 1'b1; req_wen = 1'b1; req_addr = addr; req_wdata = data;
        step();
        req_valid = 1'b0; req_wen = 1'($urandom); req_addr = 10'($urandom);
        req_wdata = $urandom;
        n_cmp++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_accept resp_valid=%b req_ready=%b want 0/0", resp_valid, req_ready);
        end
        while (aw_pend || w_pend) begin
            n_cmp++;
            if (M_AXI_AWVALID !== aw_pend || M_AXI_WVALID !== w_pend || M_AXI_BREADY !== 1'b0
                || (aw_pend && M_AXI_AWADDR !== addr) || (w_pend && M_AXI_WDATA !== data)) begin
                n_fail++;
                $display("FAIL wr_chan c=%0d awv=%b wv=%b awaddr=%h wdata=%h bready=%b want %b %b %h %h 0",
                         c, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_BREADY,
                         aw_pend, w_pend, addr, data);
            end
            M_AXI_AWREADY = (c >= aw_dly);
            M_AXI_WREADY  = (c >= w_dly);
            M_AXI_BVALID  = 1'($urandom);
            M_AXI_RVALID  = 1'($urandom);
            step();
            if (M_AXI_AWREADY) aw_pend = 1'b0;
            if (M_AXI_WREADY)  w_pend  = 1'b0;
            c++;
            if (c > 64) begin
                n_cmp++; n_fail++;
                $display("FAIL wr_timeout got=pending want=done");
                break;
            end
        end
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_RVALID = 1'b0;
        for (int i = 0; i <= b_dly; i++) begin
            n_cmp++;
            if (M_AXI_BREADY !== 1'b1 || M_AXI_AWVALID !== 1'b0 || M_AXI_WVALID !== 1'b0
                || resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL wresp_wait bready=%b awv=%b wv=%b resp_valid=%b want 1 0 0 0",
                         M_AXI_BREADY, M_AXI_AWVALID, M_AXI_WVALID, resp_valid);
            end
            if (i == b_dly) begin
                M_AXI_BVALID = 1'b1; M_AXI_BRESP = bresp;
            end
            step();
        end
        M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'($urandom);
        exp_err = bresp[1];
        mem[addr[9:2]] = data;
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_err !== exp_err || resp_rdata !== exp_rdata
            || req_ready !== 1'b1 || M_AXI_BREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done valid=%b err=%b rdata=%h ready=%b bready=%b want 1 %b %h 1 0",
                     resp_valid, resp_err, resp_rdata, req_ready, M_AXI_BREADY, exp_err, exp_rdata);
        end
    endtask

    task automatic run_read(input logic [9:0] addr, input int ar_dly, input int r_dly,
                            input logic [31:0] rdata, input logic [1:0] rresp);
        bit done = 1'b0;
        int c = 0;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_ready got=%b want=1", req_ready);
        end
        req_valid = 1'b1; req_wen = 1'b0; req_addr = addr; req_wdata = $urandom;
        step();
        req_valid = 1'b0; req_wen = 1'($urandom); req_addr = 10'($urandom);
        n_cmp++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_accept resp_valid=%b req_ready=%b want 0/0", resp_valid, req_ready);
        end
        while (!done) begin
            n_cmp++;
            if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== addr || M_AXI_RREADY !== 1'b0
                || M_AXI_AWVALID !== 1'b0 || M_AXI_WVALID !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_ar c=%0d arv=%b araddr=%h rready=%b awv=%b wv=%b want 1 %h 0 0 0",
                         c, M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_RREADY, M_AXI_AWVALID,
                         M_AXI_WVALID, addr);
            end
            M_AXI_ARREADY = (c >= ar_dly);
            M_AXI_BVALID  = 1'($urandom);
            M_AXI_RVALID  = 1'($urandom);
            step();
            if (M_AXI_ARREADY) done = 1'b1;
            c++;
            if (c > 64) begin
                n_cmp++; n_fail++;
                $display("FAIL rd_timeout got=pending want=done");
                break;
            end
        end
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
        for (int i = 0; i <= r_dly; i++) begin
            n_cmp++;
            if (M_AXI_ARVALID !== 1'b0 || M_AXI_RREADY !== 1'b1 || resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rdata_wait arv=%b rready=%b resp_valid=%b want 0 1 0",
                         M_AXI_ARVALID, M_AXI_RREADY, resp_valid);
            end
            M_AXI_BVALID = 1'($urandom);
            if (i == r_dly) begin
                M_AXI_RVALID = 1'b1; M_AXI_RDATA = rdata; M_AXI_RRESP = rresp;
            end
            step();
        end
        M_AXI_RVALID = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_RDATA = $urandom;
        M_AXI_RRESP = 2'($urandom);
        exp_rdata = rdata;
        exp_err   = rresp[1];
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_err !== exp_err || resp_rdata !== exp_rdata
            || req_ready !== 1'b1 || M_AXI_RREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_done valid=%b err=%b rdata=%h ready=%b rready=%b want 1 %b %h 1 0",
                     resp_valid, resp_err, resp_rdata, req_ready, M_AXI_RREADY, exp_err, exp_rdata);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            n_cmp++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== exp_rdata
                || resp_err !== exp_err) begin
                n_fail++;
                $display("FAIL idle valid=%b ready=%b rdata=%h err=%b want 0 1 %h %b",
                         resp_valid, req_ready, resp_rdata, resp_err, exp_rdata, exp_err);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0
            || resp_rdata !== 32'h0 || M_AXI_AWVALID !== 1'b0 || M_AXI_WVALID !== 1'b0
            || M_AXI_ARVALID !== 1'b0 || M_AXI_BREADY !== 1'b0 || M_AXI_RREADY !== 1'b0
            || M_AXI_AWADDR !== 10'h0 || M_AXI_ARADDR !== 10'h0 || M_AXI_WDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL reset ready=%b rv=%b err=%b rdata=%h awv=%b wv=%b arv=%b br=%b rr=%b",
                     req_ready, resp_valid, resp_err, resp_rdata, M_AXI_AWVALID, M_AXI_WVALID,
                     M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY);
        end
        n_cmp++;
        if (M_AXI_WSTRB !== 4'hF) begin
            n_fail++;
            $display("FAIL wstrb got=%h want=f", M_AXI_WSTRB);
        end
        @(negedge M_AXI_ACLK);
        M_AXI_ARESETN = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_basic();
        run_read(10'h000, 1, 0, 32'h1234ABCD, 2'b00);
        idle_cycles(1);
        run_write(10'h000, 32'h1, 0, 0, 1, 2'b00);
        idle_cycles(1);
    endtask

    task automatic test_w_before_aw();
        run_write(10'h2A7, 32'hCAFE_F00D, 5, 2, 2, 2'b01);
        idle_cycles(1);
    endtask

    task automatic test_errors();
        run_write(10'h104, 32'hDEAD_BEEF, 1, 0, 0, 2'b10);
        idle_cycles(1);
        run_read(10'h104, 0, 2, 32'h0BAD_0BAD, 2'b11);
        idle_cycles(1);
    endtask

    task automatic test_back_to_back();
        run_write(10'h010, 32'hA5A5_5A5A, 0, 1, 0, 2'b00);
        run_read(10'h010, 0, 0, 32'hA5A5_5A5A, 2'b00);
        run_read(10'h3FF, 2, 1, 32'h7777_0001, 2'b00);
        idle_cycles(1);
    endtask

    task automatic test_reset_in_rdata();
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 10'h0C8;
        step();
        req_valid = 1'b0;
        M_AXI_ARREADY = 1'b1;
        step();
        M_AXI_ARREADY = 1'b0;
        n_cmp++;
        if (M_AXI_RREADY !== 1'b1 || M_AXI_ARVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pre rready=%b arv=%b want 1 0", M_AXI_RREADY, M_AXI_ARVALID);
        end
        M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'h5555_AAAA; M_AXI_RRESP = 2'b10;
        #2;
        M_AXI_ARESETN = 1'b0;
        #1;
        exp_rdata = 32'h0;
        exp_err   = 1'b0;
        n_cmp++;
        if (M_AXI_RREADY !== 1'b0 || M_AXI_ARVALID !== 1'b0 || req_ready !== 1'b1
            || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0
            || M_AXI_ARADDR !== 10'h0) begin
            n_fail++;
            $display("FAIL rst_async rready=%b arv=%b ready=%b rv=%b rdata=%h err=%b want 0 0 1 0 0 0",
                     M_AXI_RREADY, M_AXI_ARVALID, req_ready, resp_valid, resp_rdata, resp_err);
        end
        @(posedge M_AXI_ACLK);
        @(negedge M_AXI_ACLK);
        M_AXI_ARESETN = 1'b1;
        #1;
        M_AXI_RVALID = 1'b0;
        idle_cycles(3);
    endtask

    task automatic test_random();
        logic [9:0] a;
        for (int t = 0; t < 40; t++) begin
            a = 10'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                run_write(a, $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
                          $urandom_range(0, 3), 2'($urandom));
            end else begin
                run_read(a, $urandom_range(0, 4), $urandom_range(0, 3), mem[a[9:2]],
                         2'($urandom));
            end
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        M_AXI_ARESETN = 1'b0;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BRESP = 2'b00; M_AXI_BVALID = 1'b0;
        M_AXI_ARREADY = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00; M_AXI_RVALID = 1'b0;
        test_reset();
        test_basic();
        test_w_before_aw();
        test_errors();
        test_back_to_back();
        test_reset_in_rdata();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_master_if.md
AXI_LITE_MASTER_IF -- requirements
Module: axi_lite_master_if

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, AXI address width; data width fixed at 32.
REQ-002 SHALL have M_AXI_ACLK  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have M_AXI_ARESETN  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have req_valid  input  1  requester presents a transaction.
REQ-005 SHALL have req_ready  output  1  block idle, request accepted on req_valid&req_ready.
REQ-006 SHALL have req_wen  input  1  1=write, 0=read.
REQ-007 SHALL have req_addr  input  ADDR_WIDTH  transaction byte address.
REQ-008 SHALL have req_wdata  input  32  write data.
REQ-009 SHALL have resp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have resp_rdata  output  32  data of most recent completed read.
REQ-011 SHALL have resp_err  output  1  completion response bit [1] (SLVERR/DECERR).
REQ-012 SHALL have M_AXI_AWADDR  output  ADDR_WIDTH  write address.
REQ-013 SHALL have M_AXI_AWVALID  output  1  write address valid.
REQ-014 SHALL have M_AXI_AWREADY  input  1  write address accepted.
REQ-015 SHALL have M_AXI_WDATA  output  32  write data.
REQ-016 SHALL have M_AXI_WSTRB  output  4  byte strobes, constant 4'hF.
REQ-017 SHALL have M_AXI_WVALID  output  1  write data valid.
REQ-018 SHALL have M_AXI_WREADY  input  1  write data accepted.
REQ-019 SHALL have M_AXI_BRESP  input  2  write response.
REQ-020 SHALL have M_AXI_BVALID  input  1  write response valid.
REQ-021 SHALL have M_AXI_BREADY  output  1  master accepts write response.
REQ-022 SHALL have M_AXI_ARADDR  output  ADDR_WIDTH  read address.
REQ-023 SHALL have M_AXI_ARVALID  output  1  read address valid.
REQ-024 SHALL have M_AXI_ARREADY  input  1  read address accepted.
REQ-025 SHALL have M_AXI_RDATA  input  32  read data.
REQ-026 SHALL have M_AXI_RRESP  input  2  read response.
REQ-027 SHALL have M_AXI_RVALID  input  1  read data valid.
REQ-028 SHALL have M_AXI_RREADY  output  1  master accepts read data.

Function
REQ-029 SHALL implement FSM IDLE, WRITE, WRESP, READ, RDATA; one outstanding transaction max; req_ready = (state==IDLE).
REQ-030 SHALL, on accept in IDLE, latch req_addr/req_wdata into AWADDR/ARADDR/WDATA registers (low 2 address bits forwarded unchanged), go to WRITE if req_wen else READ.
REQ-031 SHALL in WRITE hold AWVALID and WVALID both high from the first WRITE cycle, never waiting on AWREADY/WREADY before asserting VALID (slaves may require both valids together).
REQ-032 SHALL drop AWVALID the cycle after AWVALID&AWREADY and WVALID the cycle after WVALID&WREADY independently; same-cycle or either-order handshakes both legal.
REQ-033 SHALL go WRITE->WRESP when both handshakes have completed (incl. both in the same cycle); BREADY=1 only in WRESP.
REQ-034 SHALL in WRESP on BVALID: register resp_err=BRESP[1], pulse resp_valid next cycle, return to IDLE; resp_rdata unchanged.
REQ-035 SHALL in READ hold ARVALID high until ARVALID&ARREADY, then go to RDATA with ARVALID low; RREADY=1 only in RDATA.
REQ-036 SHALL in RDATA on RVALID: register resp_rdata=RDATA, resp_err=RRESP[1], pulse resp_valid next cycle, return to IDLE.
REQ-037 SHALL keep address/data/strobe outputs stable while corresponding VALID is high; VALID never drops before handshake.
REQ-038 SHALL make resp_valid exactly one cycle, coincident with req_ready returning 1; new request accepted that same cycle.
REQ-039 SHALL ignore BVALID/RVALID outside WRESP/RDATA; no timeout, a non-responding slave stalls the block indefinitely.

Reset
REQ-040 SHALL on ARESETN low immediately: state IDLE, all VALIDs, BREADY, RREADY, resp_valid, resp_err =0, AWADDR/ARADDR/WDATA/resp_rdata =0, req_ready=1; in-flight transaction abandoned, no resp_valid.

Verification
REQ-041 Read 0x000, slave ARREADY 1 cycle after ARVALID, RVALID with RDATA=0x1234ABCD RRESP=0 -> one resp_valid pulse, resp_rdata=0x1234ABCD, resp_err=0.
REQ-042 Write 0x000 data 0x1, slave needs AWVALID&WVALID together -> both high same cycle, B OKAY -> resp_valid pulse, resp_err=0, resp_rdata unchanged.
REQ-043 WREADY 3 cycles before AWREADY, AWREADY held low 5 cycles -> WVALID drops after W handshake, AWVALID/AWADDR stable until AWREADY, then WRESP.
REQ-044 Write with BRESP=2'b10 then read with RRESP=2'b11 -> resp_err=1 on both completions.
REQ-045 Back-to-back: new req_valid held high during resp_valid cycle -> accepted that cycle, ARVALID high the next.
REQ-046 ARESETN low while in RDATA -> RREADY/ARVALID low asynchronously, no resp_valid, req_ready=1 after release.
